// File: rtl/nor_tree_pkg.sv
// Shared types and elaboration-time sizing helpers for the pipelined NOR-family reduction tree.
package nor_tree_pkg;

  typedef enum logic [1:0] {
    MODE_NOR  = 2'b00,
    MODE_OR   = 2'b01,
    MODE_NAND = 2'b10,
    MODE_AND  = 2'b11
  } mode_e;

  // Smallest L >= 1 with fanin**L >= nin.
  function automatic int tree_levels(input int nin, input int fanin);
    int     lvl;
    longint span;
    lvl  = 1;
    span = fanin;
    while (span < nin) begin
      span = span * fanin;
      lvl  = lvl + 1;
    end
    return lvl;
  endfunction

  // Nodes present after 'level' reductions; level 0 is the conditioned input width.
  function automatic int node_count(input int nin, input int fanin, input int level);
    int n;
    n = nin;
    for (int i = 0; i < level; i++) n = (n + fanin - 1) / fanin;
    return n;
  endfunction

endpackage

// File: rtl/nor_tree_tgl_cnt.sv
// Per-channel saturating toggle counter; counts changes between successive valid output beats.
module nor_tree_tgl_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             vld,
  input  logic             q,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  logic prev;

  // clr has priority over an increment but leaves the reference value untouched.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      prev <= 1'b0;
      cnt  <= '0;
    end else begin
      if (vld) prev <= q;
      if (clr) cnt <= '0;
      else if (vld && (q != prev) && (cnt != '1)) cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/nor_tree_pipe.sv
// Multi-channel pipelined NOR/OR/NAND/AND reduction built from FANIN-input OR levels,
// with a saturating toggle counter on every channel output.
module nor_tree_pipe
  import nor_tree_pkg::*;
#(
  parameter int NIN   = 9,
  parameter int FANIN = 3,
  parameter int CH    = 4,
  parameter int CNT_W = 8
) (
  input  logic                clk,
  input  logic                rstb,
  input  logic [CH*NIN-1:0]   in,
  input  logic                in_vld,
  input  logic [1:0]          mode,
  input  logic                cnt_clr,
  output logic [CH-1:0]       qn,
  output logic                out_vld,
  output logic [CH*CNT_W-1:0] tgl_cnt
);

  localparam int LVL = tree_levels(NIN, FANIN);

  // Valid semantics: in_vld qualifies in/mode at a rising edge; there is no back-pressure.
  // out_vld qualifies qn for exactly one cycle; qn holds its last valid value otherwise.
  logic [CH-1:0][NIN-1:0] s0_x;
  logic                   s0_vld;
  logic [1:0]             s0_mode;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      s0_x    <= '0;
      s0_vld  <= 1'b0;
      s0_mode <= 2'b00;
    end else begin
      for (int c = 0; c < CH; c++) s0_x[c] <= in[c*NIN +: NIN] ^ {NIN{mode[1]}};
      s0_vld  <= in_vld;
      s0_mode <= mode;
    end
  end

  for (genvar l = 1; l <= LVL; l++) begin : g_lvl
    localparam int PW = node_count(NIN, FANIN, l - 1);
    localparam int NW = node_count(NIN, FANIN, l);

    logic [CH-1:0][PW-1:0] src;
    logic                  src_vld;
    logic [1:0]            src_mode;
    logic [CH-1:0][NW-1:0] nodes;
    logic [CH-1:0][NW-1:0] q;
    logic                  vld;

    if (l == 1) begin : g_head
      assign src      = s0_x;
      assign src_vld  = s0_vld;
      assign src_mode = s0_mode;
    end else begin : g_link
      assign src      = g_lvl[l-1].q;
      assign src_vld  = g_lvl[l-1].vld;
      assign src_mode = g_lvl[l-1].g_mid.mode_q;
    end

    // The last group of a level may be short; zero padding is neutral for OR.
    always_comb begin
      logic [NW*FANIN-1:0] padded;
      padded = '0;
      nodes  = '0;
      for (int c = 0; c < CH; c++) begin
        padded         = '0;
        padded[PW-1:0] = src[c];
        for (int j = 0; j < NW; j++) nodes[c][j] = |padded[j*FANIN +: FANIN];
      end
    end

    if (l < LVL) begin : g_mid
      logic [1:0] mode_q;
      always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
          q      <= '0;
          vld    <= 1'b0;
          mode_q <= 2'b00;
        end else begin
          q      <= nodes;
          vld    <= src_vld;
          mode_q <= src_mode;
        end
      end
    end else begin : g_last
      // Final level folds in the output polarity and only updates on valid beats.
      always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
          q   <= '0;
          vld <= 1'b0;
        end else begin
          vld <= src_vld;
          if (src_vld) begin
            for (int c = 0; c < CH; c++) q[c][0] <= nodes[c][0] ^ ~src_mode[0] ^ src_mode[1];
          end
        end
      end
    end
  end

  assign out_vld = g_lvl[LVL].vld;

  for (genvar c = 0; c < CH; c++) begin : g_ch
    assign qn[c] = g_lvl[LVL].q[c][0];

    nor_tree_tgl_cnt #(
      .CNT_W(CNT_W)
    ) u_cnt (
      .clk  (clk),
      .rstb (rstb),
      .vld  (out_vld),
      .q    (qn[c]),
      .clr  (cnt_clr),
      .cnt  (tgl_cnt[c*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_nor_tree_pipe.sv
// Directed bench for nor_tree_pipe: default configuration with a scoreboard, plus two corner configurations.
module tb_nor_tree_pipe;
  import nor_tree_pkg::*;

  localparam int CH    = 4;
  localparam int NIN   = 9;
  localparam int CNT_W = 8;
  localparam int LAT   = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstb = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [CH*NIN-1:0]   din;
  logic                in_vld;
  logic [1:0]          mode;
  logic                cnt_clr;
  logic [CH-1:0]       qn;
  logic                out_vld;
  logic [CH*CNT_W-1:0] tgl_cnt;

  logic [0:0] n1_in;
  logic       n1_vld;
  logic [1:0] n1_mode;
  logic [0:0] n1_qn;
  logic       n1_ovld;
  logic [7:0] n1_cnt;

  logic [9:0] n10_in;
  logic       n10_vld;
  logic [1:0] n10_mode;
  logic [0:0] n10_qn;
  logic       n10_ovld;
  logic [7:0] n10_cnt;

  nor_tree_pipe #(.NIN(NIN), .FANIN(3), .CH(CH), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .rstb(rstb), .in(din), .in_vld(in_vld), .mode(mode), .cnt_clr(cnt_clr),
    .qn(qn), .out_vld(out_vld), .tgl_cnt(tgl_cnt)
  );

  nor_tree_pipe #(.NIN(1), .FANIN(3), .CH(1), .CNT_W(8)) u_n1 (
    .clk(clk), .rstb(rstb), .in(n1_in), .in_vld(n1_vld), .mode(n1_mode), .cnt_clr(cnt_clr),
    .qn(n1_qn), .out_vld(n1_ovld), .tgl_cnt(n1_cnt)
  );

  nor_tree_pipe #(.NIN(10), .FANIN(3), .CH(1), .CNT_W(8)) u_n10 (
    .clk(clk), .rstb(rstb), .in(n10_in), .in_vld(n10_vld), .mode(n10_mode), .cnt_clr(cnt_clr),
    .qn(n10_qn), .out_vld(n10_ovld), .tgl_cnt(n10_cnt)
  );

  // ---------------- scoreboard / model ----------------
  int checks = 0;
  int errors = 0;

  logic [CH-1:0]    exp_q[$];
  logic             vld_q[$];
  logic [CH-1:0]    m_qn;
  logic [CH-1:0]    m_prev;
  logic             m_vld;
  logic [CNT_W-1:0] m_cnt[CH];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CH-1:0] ref_fn(input logic [CH*NIN-1:0] d, input logic [1:0] m);
    logic [CH-1:0]  r;
    logic [NIN-1:0] v;
    r = '0;
    for (int c = 0; c < CH; c++) begin
      v = d[c*NIN +: NIN];
      case (m)
        MODE_NOR:  r[c] = ~(|v);
        MODE_OR:   r[c] = |v;
        MODE_NAND: r[c] = ~(&v);
        default:   r[c] = &v;
      endcase
    end
    return r;
  endfunction

  function automatic logic [CH*NIN-1:0] rand_din();
    logic [CH*NIN-1:0] d;
    d = '0;
    for (int c = 0; c < CH; c++) begin
      case ($urandom_range(0, 3))
        0:       d[c*NIN +: NIN] = '0;
        1:       d[c*NIN +: NIN] = '1;
        default: d[c*NIN +: NIN] = NIN'($urandom_range(0, 511));
      endcase
    end
    return d;
  endfunction

  task automatic model_clear();
    exp_q.delete();
    vld_q.delete();
    m_qn   = '0;
    m_prev = '0;
    m_vld  = 1'b0;
    for (int c = 0; c < CH; c++) m_cnt[c] = '0;
  endtask

  // One clock: record the driven beat, advance the model across the edge, compare #1 later.
  task automatic tick();
    logic clr_s;
    if (in_vld) exp_q.push_back(ref_fn(din, mode));
    vld_q.push_back(in_vld);
    clr_s = cnt_clr;
    @(posedge clk);
    for (int c = 0; c < CH; c++) begin
      if (clr_s) m_cnt[c] = '0;
      else if (m_vld && (m_qn[c] != m_prev[c]) && (m_cnt[c] != '1)) m_cnt[c] = m_cnt[c] + 1'b1;
    end
    if (m_vld) m_prev = m_qn;
    m_vld = 1'b0;
    if (vld_q.size() > LAT) m_vld = vld_q.pop_front();
    #1;
    check("out_vld", out_vld, m_vld);
    if (out_vld) begin
      check("sb_nonempty", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) m_qn = exp_q.pop_front();
    end
    check("qn", qn, m_qn);
    for (int c = 0; c < CH; c++) check("tgl_cnt", tgl_cnt[c*CNT_W +: CNT_W], m_cnt[c]);
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rstb = 1'b0;
    #1;
    check("rst_qn", qn, 0);
    check("rst_out_vld", out_vld, 0);
    check("rst_tgl_cnt", tgl_cnt, 0);
    check("rst_n1_qn", n1_qn, 0);
    check("rst_n10_ovld", n10_ovld, 0);
    model_clear();
    @(posedge clk);
    #1;
    rstb = 1'b1;
  endtask

  task automatic corner(input logic n1_d, input logic [9:0] n10_d, input logic [1:0] m,
                        input logic e1, input logic e10);
    n1_in   = n1_d;
    n10_in  = n10_d;
    n1_mode = m;
    n10_mode = m;
    n1_vld  = 1'b1;
    n10_vld = 1'b1;
    tick();
    n1_vld  = 1'b0;
    n10_vld = 1'b0;
    check("n1_early", n1_ovld, 0);
    tick();
    check("n1_vld", n1_ovld, 1);
    check("n1_qn", n1_qn, e1);
    check("n10_early", n10_ovld, 0);
    tick();
    check("n10_early2", n10_ovld, 0);
    tick();
    check("n10_vld", n10_ovld, 1);
    check("n10_qn", n10_qn, e10);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic b;
    din = '0; in_vld = 1'b0; mode = MODE_NOR; cnt_clr = 1'b0;
    n1_in = '0; n1_vld = 1'b0; n1_mode = MODE_NOR;
    n10_in = '0; n10_vld = 1'b0; n10_mode = MODE_NOR;
    model_clear();
    #2;
    do_reset();

    // Reset and latency: all-zero NOR beat reaches the output two edges later.
    din = '0; mode = MODE_NOR; in_vld = 1'b1;
    tick();
    in_vld = 1'b0;
    tick();
    tick();
    check("lat_qn", qn, 4'hF);
    check("lat_vld", out_vld, 1);
    tick();
    check("lat_cnt", tgl_cnt, 32'h01010101);

    // Mode sweep, mode changes every beat.
    for (int rep = 0; rep < 2; rep++) begin
      for (int k = 0; k < 4; k++) begin
        din = rand_din();
        din[NIN-1:0]     = 9'h1FF;
        din[2*NIN-1:NIN] = 9'h001;
        mode   = (rep == 0) ? 2'(k) : 2'(3 - k);
        in_vld = 1'b1;
        tick();
      end
    end
    in_vld = 1'b0;
    repeat (3) tick();

    // Bubbles: 1,0,0,1 with garbage data on the invalid beats.
    for (int k = 0; k < 4; k++) begin
      din    = rand_din();
      mode   = 2'($urandom_range(0, 3));
      in_vld = (k == 0 || k == 3);
      tick();
    end
    in_vld = 1'b0;
    repeat (3) tick();

    // Reset with beats in flight.
    din = rand_din(); in_vld = 1'b1; mode = MODE_NOR;
    tick();
    din = rand_din();
    tick();
    in_vld = 1'b0;
    do_reset();
    repeat (3) tick();

    // Saturation on channel 0.
    mode = MODE_OR; in_vld = 1'b1;
    for (int i = 0; i < 300; i++) begin
      din = rand_din();
      din[NIN-1:0] = {8'b0, i[0]};
      tick();
    end
    in_vld = 1'b0;
    repeat (3) tick();
    check("sat_cnt0", tgl_cnt[CNT_W-1:0], 8'd255);

    // Clear priority against a toggling valid beat.
    b = 1'b0; in_vld = 1'b1;
    for (int i = 0; i < 4; i++) begin
      din = '0; din[0] = b; b = ~b;
      tick();
    end
    cnt_clr = 1'b1;
    din = '0; din[0] = b; b = ~b;
    tick();
    cnt_clr = 1'b0;
    check("clr_wins", tgl_cnt[CNT_W-1:0], 8'd0);
    din = '0; din[0] = b; b = ~b;
    tick();
    check("clr_next", tgl_cnt[CNT_W-1:0], 8'd1);
    in_vld = 1'b0;
    repeat (3) tick();

    // Random mix including clears and bubbles.
    for (int i = 0; i < 40; i++) begin
      din     = rand_din();
      mode    = 2'($urandom_range(0, 3));
      in_vld  = ($urandom_range(0, 3) != 0);
      cnt_clr = ($urandom_range(0, 9) == 0);
      tick();
    end
    in_vld = 1'b0; cnt_clr = 1'b0;
    repeat (3) tick();

    // Parameter corners: NIN=1 (one level) and NIN=10 (three levels, padded last group).
    corner(1'b0, 10'h200, MODE_NOR,  1'b1, 1'b0);
    corner(1'b1, 10'h200, MODE_OR,   1'b1, 1'b1);
    corner(1'b1, 10'h1FF, MODE_AND,  1'b1, 1'b0);
    corner(1'b0, 10'h000, MODE_NAND, 1'b1, 1'b1);
    corner(1'b1, 10'h3FF, MODE_NAND, 1'b0, 1'b0);
    corner(1'b0, 10'h000, MODE_OR,   1'b0, 1'b0);
    corner(1'b1, 10'h3FF, MODE_AND,  1'b1, 1'b1);

    // ---------------- report ----------------
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
